timer_count_ctrl: RTL and testbench
===================================

Name: timer_count_ctrl

Overview:
- Sequencing controller for the 64-bit timer counter datapath; sits between the register block and the counter.
- Decides on every sys_clk cycle whether the counter increments, based on timer_en, div_en/div_val, debug halt and software counter accesses.
- Owns the prescaler and the RUN/HALT/IDLE state machine.
- Produces cnt_en for the counter and halt_ack_status for the THCSR read-back.

Parameters:
- PRESCALE_W, 8, prescaler width; must satisfy 2^MAX_DIV_VAL - 1 < 2^PRESCALE_W.
- MAX_DIV_VAL, 8, largest legal div_val; larger values are clamped to MAX_DIV_VAL.

Ports:
- sys_clk  in  1  system clock; all state updates on the rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- timer_en  in  1  TCR.timer_en level
- div_en  in  1  TCR.div_en level
- div_val  in  4  TCR.div_val; division ratio is 2^div_val
- halt_req  in  1  THCSR.halt_req level
- dbg_mode  in  1  debugger attached; a halt is honoured only when this is 1
- counter_clear  in  1  one-cycle pulse: timer disabled, counter being cleared
- counter_write_sel  in  2  software write to TDR0 (bit0) / TDR1 (bit1) this cycle
- cnt_en  out  1  counter increment strobe, combinational
- halt_ack_status  out  1  registered; 1 while in HALT
- ctrl_state  out  2  registered FSM state: 00 IDLE, 01 RUN, 10 HALT
- presc_cnt  out  PRESCALE_W  registered prescaler value (debug/verification visibility)

Behaviour:
- Reset (async, sys_rst_n=0): state=IDLE, presc_cnt=0, halt_ack_status=0. cnt_en=0 follows because state=IDLE.
- halt_cond = halt_req && dbg_mode.
- eff_div = div_en ? min(div_val, MAX_DIV_VAL) : 0.
- limit = (1 << eff_div) - 1, zero-extended to PRESCALE_W.
- FSM transitions, evaluated every edge:
  - IDLE -> RUN when timer_en=1; otherwise stay in IDLE.
  - RUN -> IDLE when timer_en=0 (takes precedence over halt); else RUN -> HALT when halt_cond=1; else stay in RUN.
  - HALT -> IDLE when timer_en=0; else HALT -> RUN when halt_cond=0; else stay in HALT.
- halt_ack_status is registered as (next_state == HALT), so it is 1 in exactly the cycles where ctrl_state=10.
- cnt_en = (state==RUN) && (presc_cnt >= limit) && (counter_write_sel==2'b00).
  - The >= comparison makes a limit reduced below presc_cnt tick immediately; no stall and no wrap.
- Prescaler update, in priority order:
  1. counter_clear=1 or next_state==IDLE: presc_cnt <= 0.
  2. counter_write_sel != 0: presc_cnt <= 0. A software write wins over the increment, and the divide period restarts after the write.
  3. state==HALT: presc_cnt holds (frozen mid-period; resumes from the same value on return to RUN).
  4. state==RUN and presc_cnt >= limit: presc_cnt <= 0.
  5. state==RUN: presc_cnt <= presc_cnt + 1.
- Latency:
  - timer_en sampled 1 at edge k gives RUN after edge k.
  - With eff_div=0, cnt_en=1 in every cycle after edge k.
  - With eff_div=N, the first cnt_en occurs in the 2^N-th RUN cycle, and then once every 2^N cycles.
- Halt during RUN: cnt_en drops in the same cycle that ctrl_state becomes HALT, i.e. one cycle after halt_cond is sampled. No increment is lost or duplicated across the halt/resume boundary.
- halt_req with dbg_mode=0 is ignored; halt_ack_status stays 0.
- Simultaneous timer_en=0 and halt_cond=1 in RUN: go to IDLE, no acknowledge.
- Reset asserted mid-HALT or mid-period: immediate return to reset values with no glitch on halt_ack_status beyond the async clear.
- div_val changes while RUN are blocked upstream by the register error check; the >= rule keeps behaviour defined if one ever occurs.

Test Plan:
- Reset, then timer_en=1 with div_en=0 for 10 cycles -> cnt_en=1 on all 10 cycles after the RUN edge; presc_cnt stays 0.
- div_en=1, div_val=3, timer_en=1 for 32 cycles -> exactly 4 cnt_en pulses, one every 8 cycles, each when presc_cnt=7; presc_cnt sequence 0..7 repeating.
- div_val=2, dbg_mode=1, halt_req raised when presc_cnt=2 and held 5 cycles, then dropped:
  - ctrl_state=10 and halt_ack_status=1 for the halt window, cnt_en=0, presc_cnt frozen at 3.
  - After resume, the next cnt_en arrives after 1 more RUN cycle.
- halt_req=1 with dbg_mode=0 while running at div_val=1 -> no state change, halt_ack_status=0, cnt_en keeps pulsing every 2 cycles.
- div_val=4 at presc_cnt=9, counter_write_sel=01 for one cycle -> cnt_en=0 that cycle, presc_cnt=0 next cycle, next cnt_en 16 cycles later.
- div_val=12 with div_en=1 -> clamped to 8, cnt_en every 256 cycles. Separately, timer_en dropped while in HALT -> ctrl_state=00, halt_ack_status=0, presc_cnt=0 on the next edge.

Source files
------------

// File: rtl/timer_count_ctrl.sv
// timer_count_ctrl
// Sequencing controller for the 64-bit timer counter. It sits between the
// register block and the counter, and it decides on every sys_clk cycle
// whether the counter increments. The block owns the prescaler and the
// IDLE/RUN/HALT state machine.
//
// Ports:
//   sys_clk            system clock; all state updates on the rising edge
//   sys_rst_n          asynchronous active-low reset
//   timer_en           TCR.timer_en level
//   div_en             TCR.div_en level
//   div_val[3:0]       TCR.div_val; the division ratio is 2^div_val
//   halt_req           THCSR.halt_req level
//   dbg_mode           debugger attached; a halt is honoured only when set
//   counter_clear      one-cycle pulse; the timer is disabled and the
//                      counter is being cleared
//   counter_write_sel  software write to TDR0 (bit0) or TDR1 (bit1)
//   cnt_en             combinational counter increment strobe
//   halt_ack_status    registered; 1 while in HALT
//   ctrl_state[1:0]    registered state: 00 IDLE, 01 RUN, 10 HALT
//   presc_cnt          registered prescaler value (debug visibility)
//
// There is no valid/ready handshake in this block. cnt_en is a
// single-cycle strobe that the counter consumes unconditionally in the
// same cycle.
module timer_count_ctrl #(
  parameter int PRESCALE_W  = 8,
  parameter int MAX_DIV_VAL = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  timer_en,
  input  logic                  div_en,
  input  logic [3:0]            div_val,
  input  logic                  halt_req,
  input  logic                  dbg_mode,
  input  logic                  counter_clear,
  input  logic [1:0]            counter_write_sel,
  output logic                  cnt_en,
  output logic                  halt_ack_status,
  output logic [1:0]            ctrl_state,
  output logic [PRESCALE_W-1:0] presc_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W-1:0] presc_d;
  logic                  ack_q;
  logic [3:0]            eff_div;
  logic [PRESCALE_W-1:0] limit;
  logic                  halt_cond;
  logic                  at_limit;
  logic                  sw_write;

  assign halt_cond = halt_req && dbg_mode;
  assign sw_write  = (counter_write_sel != 2'b00);

  // Out-of-range ratios saturate rather than wrap.
  always_comb begin
    eff_div = 4'd0;
    if (div_en) begin
      if (div_val > 4'(MAX_DIV_VAL)) begin
        eff_div = 4'(MAX_DIV_VAL);
      end else begin
        eff_div = div_val;
      end
    end
  end

  // The value (1 << eff_div) - 1 is built as a mask of eff_div low ones.
  // That keeps the value at PRESCALE_W bits without an overflow bit.
  always_comb begin
    limit = '0;
    for (int i = 0; i < PRESCALE_W; i++) begin
      if (i < int'(eff_div)) begin
        limit[i] = 1'b1;
      end
    end
  end

  // The comparison is >= and not ==. If the limit drops below the current
  // count, the prescaler ticks at once and does not wrap through 2^W.
  assign at_limit = (presc_q >= limit);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (timer_en) state_d = ST_RUN;
      ST_RUN: begin
        if (!timer_en) begin
          state_d = ST_IDLE;
        end else if (halt_cond) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (!timer_en) begin
          state_d = ST_IDLE;
        end else if (!halt_cond) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The prescaler update is in priority order. A software write restarts
  // the divide period. HALT freezes the count in the middle of the period,
  // so no increment is lost or repeated across a halt.
  always_comb begin
    presc_d = presc_q;
    if (counter_clear || (state_d == ST_IDLE)) begin
      presc_d = '0;
    end else if (sw_write) begin
      presc_d = '0;
    end else if (state_q == ST_HALT) begin
      presc_d = presc_q;
    end else if (state_q == ST_RUN) begin
      if (at_limit) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ack_q   <= (state_d == ST_HALT);
    end
  end

  assign cnt_en          = (state_q == ST_RUN) && at_limit && !sw_write;
  assign halt_ack_status = ack_q;
  assign ctrl_state      = state_q;
  assign presc_cnt       = presc_q;

endmodule

// File: tb/tb_timer_count_ctrl.sv
module tb_timer_count_ctrl;

  localparam int PW   = 8;
  localparam int MAXD = 8;

  logic          clk;
  logic          rst_n;
  logic          timer_en;
  logic          div_en;
  logic [3:0]    div_val;
  logic          halt_req;
  logic          dbg_mode;
  logic          counter_clear;
  logic [1:0]    wsel;
  logic          cnt_en;
  logic          halt_ack_status;
  logic [1:0]    ctrl_state;
  logic [PW-1:0] presc_cnt;

  int checks;
  int failures;
  int total_pulses;
  int snap;

  // Scoreboard entry: {cnt_en, halt_ack, state[1:0], presc[7:0]}
  logic [11:0] exp_q[$];
  logic [11:0] e_vec;
  logic [11:0] a_vec;

  timer_count_ctrl #(.PRESCALE_W(PW), .MAX_DIV_VAL(MAXD)) dut (
    .sys_clk           (clk),
    .sys_rst_n         (rst_n),
    .timer_en          (timer_en),
    .div_en            (div_en),
    .div_val           (div_val),
    .halt_req          (halt_req),
    .dbg_mode          (dbg_mode),
    .counter_clear     (counter_clear),
    .counter_write_sel (wsel),
    .cnt_en            (cnt_en),
    .halt_ack_status   (halt_ack_status),
    .ctrl_state        (ctrl_state),
    .presc_cnt         (presc_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  // The timer is either stopped, counting, or paused by the debugger.
  // The prescaler counts cycles of the current period. A tick fires when
  // a full period of 2^eff cycles has elapsed.
  bit m_running;
  bit m_halted;
  int m_presc;

  function automatic int model_limit();
    int e;
    e = 0;
    if (div_en) e = (int'(div_val) > MAXD) ? MAXD : int'(div_val);
    return (1 << e) - 1;
  endfunction

  bit mh_cond;
  bit mn_run;
  bit mn_halt;
  int m_lim;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_running = 1'b0;
      m_halted  = 1'b0;
      m_presc   = 0;
    end else begin
      mh_cond = halt_req && dbg_mode;
      m_lim   = model_limit();
      if (!timer_en) begin
        mn_run = 1'b0; mn_halt = 1'b0;
      end else if (!m_running && !m_halted) begin
        mn_run = 1'b1; mn_halt = 1'b0;
      end else begin
        mn_run = !mh_cond; mn_halt = mh_cond;
      end
      if (counter_clear || (!mn_run && !mn_halt) || wsel != 2'b00) m_presc = 0;
      else if (m_halted) m_presc = m_presc;
      else if (m_running) m_presc = (m_presc >= m_lim) ? 0 : m_presc + 1;
      m_running = mn_run;
      m_halted  = mn_halt;
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  logic       ec;
  logic [1:0] es;
  logic [7:0] ep;
  always @(negedge clk) begin
    ec = m_running && (m_presc >= model_limit()) && (wsel == 2'b00);
    es = m_halted ? 2'd2 : (m_running ? 2'd1 : 2'd0);
    ep = 8'(m_presc);
    exp_q.push_back({ec, m_halted, es, ep});
    e_vec = exp_q.pop_front();
    a_vec = {cnt_en, halt_ack_status, ctrl_state, presc_cnt};
    checks++;
    if (a_vec !== e_vec) begin
      failures++;
      $display("FAIL cycle_cmp t=%0t actual{cnt,ack,st,presc}=%h required=%h",
               $time, a_vec, e_vec);
    end
    if (cnt_en === 1'b1) total_pulses++;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_presc(input int v, input int bound);
    int n;
    n = 0;
    while (int'(presc_cnt) != v && n < bound) begin
      cyc(1);
      n++;
    end
    chk("wait_presc", int'(presc_cnt), v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; failures = 0; total_pulses = 0;
    rst_n = 1'b0; timer_en = 1'b0; div_en = 1'b0; div_val = 4'd0;
    halt_req = 1'b0; dbg_mode = 1'b0; counter_clear = 1'b0; wsel = 2'b00;
    cyc(3);
    chk("rst_state", int'(ctrl_state), 0);
    chk("rst_ack", int'(halt_ack_status), 0);
    chk("rst_presc", int'(presc_cnt), 0);
    chk("rst_cnt_en", int'(cnt_en), 0);
    rst_n = 1'b1;
    cyc(1);

    // With no division, the counter ticks on every RUN cycle.
    timer_en = 1'b1;
    snap = total_pulses;
    cyc(11);
    chk("nodiv_pulses", total_pulses - snap, 10);
    chk("nodiv_presc", int'(presc_cnt), 0);

    // With div_val=3, the counter ticks once every 8 cycles.
    timer_en = 1'b0;
    cyc(2);
    div_en = 1'b1; div_val = 4'd3; timer_en = 1'b1;
    cyc(1);
    snap = total_pulses;
    cyc(32);
    chk("div3_pulses", total_pulses - snap, 4);
    chk("div3_presc_end", int'(presc_cnt), 0);

    // Halt in the middle of a period, then resume.
    div_val = 4'd2; dbg_mode = 1'b1;
    wait_presc(2, 20);
    halt_req = 1'b1;
    cyc(1);
    chk("halt_state", int'(ctrl_state), 2);
    chk("halt_ack", int'(halt_ack_status), 1);
    chk("halt_presc", int'(presc_cnt), 3);
    snap = total_pulses;
    cyc(4);
    chk("halt_no_pulse", total_pulses - snap, 0);
    chk("halt_frozen", int'(presc_cnt), 3);
    halt_req = 1'b0;
    snap = total_pulses;
    cyc(2);
    chk("resume_pulse", total_pulses - snap, 1);

    // A halt request without debug mode is ignored.
    dbg_mode = 1'b0; div_val = 4'd1; halt_req = 1'b1;
    snap = total_pulses;
    cyc(10);
    chk("nodbg_pulses", total_pulses - snap, 5);
    chk("nodbg_state", int'(ctrl_state), 1);
    chk("nodbg_ack", int'(halt_ack_status), 0);

    // A software write restarts the period.
    halt_req = 1'b0; div_val = 4'd4;
    wait_presc(9, 40);
    wsel = 2'b01;
    cyc(1);
    wsel = 2'b00;
    chk("wr_presc_zero", int'(presc_cnt), 0);
    snap = total_pulses;
    cyc(15);
    chk("wr_no_early", total_pulses - snap, 0);
    cyc(1);
    chk("wr_pulse16", total_pulses - snap, 1);

    // A div_val above the maximum is clamped to 8.
    timer_en = 1'b0; div_val = 4'd12;
    cyc(1);
    timer_en = 1'b1;
    cyc(1);
    snap = total_pulses;
    cyc(512);
    chk("clamp_pulses", total_pulses - snap, 2);

    // Dropping timer_en while in HALT.
    dbg_mode = 1'b1; halt_req = 1'b1;
    cyc(1);
    chk("halt2_state", int'(ctrl_state), 2);
    timer_en = 1'b0;
    cyc(1);
    chk("dis_state", int'(ctrl_state), 0);
    chk("dis_ack", int'(halt_ack_status), 0);
    chk("dis_presc", int'(presc_cnt), 0);

    // Asynchronous reset in the middle of a halt.
    timer_en = 1'b1;
    cyc(2);
    chk("halt3_ack", int'(halt_ack_status), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ack", int'(halt_ack_status), 0);
    chk("async_rst_state", int'(ctrl_state), 0);
    cyc(1);
    rst_n = 1'b1; halt_req = 1'b0;
    cyc(1);

    // Randomized traffic checked against the model on every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0)
        div_val = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(5, 15))
                                              : 4'($urandom_range(0, 4));
      if ($urandom_range(0, 31) == 0) div_en = ~div_en;
      timer_en      = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) halt_req = ~halt_req;
      if ($urandom_range(0, 15) == 0) dbg_mode = ~dbg_mode;
      counter_clear = ($urandom_range(0, 39) == 0);
      wsel          = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rst_n         = ($urandom_range(0, 299) != 0);
      cyc(1);
    end
    rst_n = 1'b1; counter_clear = 1'b0; wsel = 2'b00;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
